// File: rtl/serializer_arbiter.sv
// -----------------------------------------------------------------------------
// serializer_arbiter
//
// Two word-level requesters share one word-to-chunk serializer. A round-robin
// arbiter grants one requester and captures its word into a shift register.
// The word is then sent MSB chunk first over a valid/ready chunk stream.
// A new word can be granted in the same cycle that the final chunk of the
// current word handshakes, so back-to-back words have no bubble cycles.
//
// Parameters
//   WORD_W   width of each requester word; must be an exact multiple of CHUNK_W
//   CHUNK_W  width of each output chunk
//   NCHUNK   (derived) chunks per word, must be >= 2
//   CNT_W    (derived) chunk counter width
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   req0_valid   requester 0 offers a word
//   req0_data    requester 0 word
//   req0_ready   requester 0 word accepted this cycle (combinational)
//   req1_valid   requester 1 offers a word
//   req1_data    requester 1 word
//   req1_ready   requester 1 word accepted this cycle (combinational)
//   out_valid    chunk available
//   out_data     current chunk (from registers only)
//   out_last     current chunk is the final chunk of the word
//   out_src      requester that owns the current word
//   out_ready    downstream accepts the chunk
//   busy         a word is being serialized (same as out_valid)
//
// Build option
//   SERIALIZER_ARBITER_PARITY_EN : append one parity chunk per word, the XOR
//   of all data chunks. out_last then marks only the parity chunk.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no word held, grant window open
// SEND  | word held in shift register, cnt selects the chunk on the bus
// -----------------------------------------------------------------------------
module serializer_arbiter #(
   parameter int WORD_W  = 32,
   parameter int CHUNK_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   input  logic [WORD_W-1:0]  req0_data,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [WORD_W-1:0]  req1_data,
   output logic               req1_ready,
   output logic               out_valid,
   output logic [CHUNK_W-1:0] out_data,
   output logic               out_last,
   output logic               out_src,
   input  logic               out_ready,
   output logic               busy
);

   localparam int NCHUNK = WORD_W / CHUNK_W;

`ifdef SERIALIZER_ARBITER_PARITY_EN
   // cnt must reach NCHUNK to address the parity chunk.
   localparam int CNT_W = $clog2(NCHUNK + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK);
`else
   localparam int CNT_W = $clog2(NCHUNK);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
`endif

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WORD_W-1:0]  shreg;
   logic [CNT_W-1:0]   cnt;
   logic               prio;
   logic               src;

   logic               in_send;
   logic               at_last;
   logic               hs;
   logic               win;
   logic               gnt0;
   logic               gnt1;
   logic               gnt;
   logic [CHUNK_W-1:0] head;

`ifdef SERIALIZER_ARBITER_PARITY_EN
   logic [CHUNK_W-1:0] par_acc;
`endif

   assign head = shreg[WORD_W-1 -: CHUNK_W];

   // ---------------------------------------------------------------------------
   // Arbitration. The grant window is IDLE or the final-chunk handshake.
   // Grants are masked during reset so no ready leaks out while rst is high.
   // ---------------------------------------------------------------------------
   always_comb begin
      in_send = (state == SEND);
      at_last = in_send && (cnt == LAST_CNT);
      hs      = in_send && out_ready;
      win     = !rst && (!in_send || (hs && at_last));
      gnt0    = win && req0_valid && (!req1_valid || !prio);
      gnt1    = win && req1_valid && (!req0_valid ||  prio);
      gnt     = gnt0 || gnt1;
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (gnt) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (hs && at_last) begin
               state_nxt = gnt ? SEND : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      out_valid  = in_send;
      busy       = in_send;
      out_last   = at_last;
      out_src    = src;
      req0_ready = gnt0;
      req1_ready = gnt1;
`ifdef SERIALIZER_ARBITER_PARITY_EN
      out_data   = at_last ? par_acc : head;
`else
      out_data   = head;
`endif
   end

   // ---------------------------------------------------------------------------
   // Datapath: shift register, chunk counter, priority pointer, owner.
   // The final handshake never shifts; cnt returns to 0 through the grant
   // path, and an ungranted window simply leaves cnt parked until next grant.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
         prio  <= 1'b0;
         src   <= 1'b0;
      end else if (gnt) begin
         shreg <= gnt1 ? req1_data : req0_data;
         src   <= gnt1;
         cnt   <= '0;
         prio  <= !gnt1;
      end else if (hs && !at_last) begin
         shreg <= shreg << CHUNK_W;
         cnt   <= cnt + CNT_W'(1);
      end
   end

`ifdef SERIALIZER_ARBITER_PARITY_EN
   // Every data chunk passes through here before the parity chunk is reached,
   // so by the time cnt hits LAST_CNT the accumulator holds the full XOR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_acc <= '0;
      end else if (gnt) begin
         par_acc <= '0;
      end else if (hs && !at_last) begin
         par_acc <= par_acc ^ head;
      end
   end
`endif

endmodule

// File: tb/tb_serializer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serializer_arbiter
//
// Scoreboard bench for serializer_arbiter. A word-level reference model
// (chunks remaining in the current word plus the priority bit) predicts
// grants; each predicted grant pushes the word's chunk sequence into a queue.
// An independent monitor pops and compares on every chunk handshake and checks
// that the bus is frozen while stalled.
// -----------------------------------------------------------------------------
module tb_serializer_arbiter;

   localparam int WORD_W  = 32;
   localparam int CHUNK_W = 8;
   localparam int NCHUNK  = WORD_W / CHUNK_W;
`ifdef SERIALIZER_ARBITER_PARITY_EN
   localparam int NTOT = NCHUNK + 1;
`else
   localparam int NTOT = NCHUNK;
`endif

   logic               clk;
   logic               rst;
   logic               req0_valid;
   logic [WORD_W-1:0]  req0_data;
   logic               req0_ready;
   logic               req1_valid;
   logic [WORD_W-1:0]  req1_data;
   logic               req1_ready;
   logic               out_valid;
   logic [CHUNK_W-1:0] out_data;
   logic               out_last;
   logic               out_src;
   logic               out_ready;
   logic               busy;

   serializer_arbiter #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_src    (out_src),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [CHUNK_W-1:0] data;
      logic               last;
      logic               src;
   } chunk_t;

   chunk_t sb[$];

   int tests = 0;
   int fails = 0;
   int left  = 0;      // chunks of the current word still to handshake
   bit prio_m = 1'b0;  // requester favoured on contention
   int r0_cnt = 0;
   int r1_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [WORD_W-1:0] w, input logic s);
      logic [CHUNK_W-1:0] c;
      logic [CHUNK_W-1:0] par;
      par = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         c = CHUNK_W'(w >> (WORD_W - CHUNK_W * (i + 1)));
         par ^= c;
         sb.push_back('{data: c, last: (i == NTOT - 1), src: s});
      end
      if (NTOT > NCHUNK) sb.push_back('{data: par, last: 1'b1, src: s});
   endtask

   // One clock of stimulus. Called at posedge+1; returns at the next posedge+1.
   task automatic step(input logic v0, input logic [WORD_W-1:0] d0,
                       input logic v1, input logic [WORD_W-1:0] d1,
                       input logic ordy, output bit g0, output bit g1);
      bit win;
      req0_valid = v0; req0_data = d0;
      req1_valid = v1; req1_data = d1;
      out_ready  = ordy;
      @(negedge clk);
      win = (left == 0) || (ordy && left == 1);
      g0  = win && v0 && (!v1 || !prio_m);
      g1  = win && v1 && (!v0 ||  prio_m);
      check("req0_ready", req0_ready, g0);
      check("req1_ready", req1_ready, g1);
      check("out_valid", out_valid, left != 0);
      check("busy", busy, left != 0);
      r0_cnt += int'(req0_ready);
      r1_cnt += int'(req1_ready);
      if (g0) push_word(d0, 1'b0);
      if (g1) push_word(d1, 1'b1);
      if (g0 || g1) prio_m = g0;
      @(posedge clk); #1;
      if (g0 || g1)              left = NTOT;
      else if (left > 0 && ordy) left--;
   endtask

   task automatic idle(input int n);
      bit a, b;
      for (int i = 0; i < n; i++) step(0, '0, 0, '0, 1, a, b);
   endtask

   // Monitor: compare every handshaken chunk against the scoreboard and make
   // sure a stalled chunk does not change.
   initial begin : monitor
      bit hold;
      chunk_t h;
      chunk_t e;
      hold = 0;
      h = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 0;
         end else begin
            if (hold) begin
               check("stall_valid", out_valid, 1);
               check("stall_data", out_data, h.data);
               check("stall_last", out_last, h.last);
               check("stall_src", out_src, h.src);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL extra_chunk: got %0h expected no chunk at %0t", out_data, $time);
               end else begin
                  e = sb.pop_front();
                  check("chunk_data", out_data, e.data);
                  check("chunk_last", out_last, e.last);
                  check("chunk_src", out_src, e.src);
               end
            end
            hold = out_valid && !out_ready;
            h = '{data: out_data, last: out_last, src: out_src};
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit g0, g1, acc0, acc1, p0, p1;
      logic [WORD_W-1:0] d0, d1;
      int s0, s1;

      rst = 1'b1;
      req0_valid = 0; req0_data = '0;
      req1_valid = 0; req1_data = '0;
      out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_src", out_src, 0);
      req0_valid = 1; req1_valid = 1;
      #1;
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      req0_valid = 0; req1_valid = 0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Contention from reset: req0 wins, req1 follows with no gap.
      acc0 = 0; acc1 = 0;
      for (int i = 0; i < 2 * NTOT + 2; i++) begin
         step(!acc0, 32'h11223344, !acc1, 32'h55667788, 1, g0, g1);
         acc0 |= g0; acc1 |= g1;
      end
      check("contention_both_accepted", {30'd0, acc0, acc1}, 3);

      // Fairness: both continuously valid for four words.
      s0 = r0_cnt; s1 = r1_cnt;
      for (int i = 0; i < 4 * NTOT; i++)
         step(1, $urandom, 1, $urandom, 1, g0, g1);
      idle(NTOT + 1);
      check("fair_req0_grants", r0_cnt - s0, 2);
      check("fair_req1_grants", r1_cnt - s1, 2);

      // Single word.
      step(1, 32'hDEADBEEF, 0, '0, 1, g0, g1);
      check("single_grant", g0, 1);
      idle(NTOT + 1);

      // Backpressure: three stalled cycles after the first chunk appears,
      // with requester 1 knocking during the stall.
      step(1, 32'hA1B2C3D4, 0, '0, 1, g0, g1);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 32'h0BADF00D, 0, g0, g1);
      acc1 = 0;
      for (int i = 0; i < 2 * NTOT + 2; i++) begin
         step(0, '0, !acc1, 32'h0BADF00D, 1, g0, g1);
         acc1 |= g1;
      end

`ifdef SERIALIZER_ARBITER_PARITY_EN
      step(1, 32'h01020304, 0, '0, 1, g0, g1);
      idle(NTOT + 1);
`endif

      // Reset mid-word, after two chunks of the word have gone out.
      step(1, 32'hCAFEF00D, 0, '0, 1, g0, g1);
      step(0, '0, 0, '0, 1, g0, g1);
      step(0, '0, 0, '0, 1, g0, g1);
      rst = 1'b1;
      req0_valid = 1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_req0_ready", req0_ready, 0);
      sb.delete();
      left = 0;
      prio_m = 1'b0;
      req0_valid = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(NTOT + 1);
      // Priority pointer must be back at requester 0.
      step(1, 32'h13579BDF, 1, 32'h2468ACE0, 1, g0, g1);
      check("post_rst_prio", g0, 1);
      idle(NTOT + 1);

      // Randomized traffic: sticky valids, data may change while waiting.
      p0 = 0; p1 = 0; d0 = '0; d1 = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!p0 && $urandom_range(0, 3) == 0) begin p0 = 1; d0 = $urandom; end
         else if (p0 && $urandom_range(0, 7) == 0) d0 = $urandom;
         if (!p1 && $urandom_range(0, 3) == 0) begin p1 = 1; d1 = $urandom; end
         else if (p1 && $urandom_range(0, 7) == 0) d1 = $urandom;
         step(p0, d0, p1, d1, $urandom_range(0, 3) != 0, g0, g1);
         if (g0) p0 = 0;
         if (g1) p1 = 0;
      end

      idle(NTOT + 3);
      check("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serializer_arbiter.md
Name: serializer_arbiter

Overview:
- Shares one word-to-chunk serializer between two word-level requesters.
- Round-robin arbiter picks a requester and captures its word. A sequencer then shifts the word out MSB-chunk-first over a valid/ready chunk stream, with a chunk counter and last flag.
- Sits between the packet-assembly stage and the link transmitter in the networking layer.

Parameters:
- WORD_W, 32, width of each requester word; must be an exact multiple of CHUNK_W.
- CHUNK_W, 8, width of each output chunk.
- NCHUNK, WORD_W/CHUNK_W, derived; chunks per word; must be >= 2.
- CNT_W, $clog2(NCHUNK), derived; chunk counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  requester 0 offers a word.
- req0_data  in  WORD_W  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 offers a word.
- req1_data  in  WORD_W  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- out_valid  out  1  chunk available.
- out_data  out  CHUNK_W  current chunk.
- out_last  out  1  current chunk is the final chunk of the word.
- out_src  out  1  index of the requester that owns the current word.
- out_ready  in  1  downstream accepts chunk.
- busy  out  1  a word is being serialized (equals out_valid).

Behaviour:
- States:
  - IDLE: no word held.
  - SEND: word held in the shift register, chunk counter cnt at 0..NCHUNK-1.
- Grant window: in IDLE, or in SEND on the cycle the last chunk handshakes (out_valid & out_ready & out_last).
- Arbitration in the grant window:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the requester named by priority pointer prio.
  - reqN_ready is combinational and high only for the granted requester.
  - At most one ready is high per cycle; ready is never high outside the grant window.
- On a grant:
  - Capture reqN_data into the shift register and set out_src <= N.
  - Clear cnt to 0, set prio <= ~N, enter or stay in SEND.
  - Back-to-back words therefore have zero bubble cycles.
- Grant window with no valid request: SEND -> IDLE; prio unchanged.
- SEND outputs:
  - out_valid = 1.
  - out_data = shift register bits [WORD_W-1 : WORD_W-CHUNK_W].
  - out_last = (cnt == NCHUNK-1).
- Chunk handshake (out_valid & out_ready), not last: shift register <<= CHUNK_W (zero fill), cnt += 1.
- out_ready low: all state holds; out_data, out_last and out_src are stable while out_valid is high.
- out_data and out_src are registered/derived from registers, never combinational from req inputs.
- Latency: word accepted at edge T -> first chunk valid in the cycle after T. With out_ready held high, a word occupies exactly NCHUNK cycles.
- Reset values:
  - State IDLE, cnt 0, shift register 0, prio 0 (requester 0 favoured), out_src 0.
  - out_valid 0, out_last 0, busy 0, out_data 0.
  - req0_ready and req1_ready 0 regardless of valid.
- Reset mid-word: partially sent word is discarded; no chunk is re-emitted after reset release.
- cnt never wraps past NCHUNK-1; the last handshake resets it to 0 through the grant path.
- Requester data changing while its valid is high and ready is low has no effect.

Optional Feature:
- Macro: SERIALIZER_ARBITER_PARITY_EN.
- Defined:
  - After the last data chunk, one extra chunk is emitted: the XOR of all NCHUNK data chunks of the word.
  - out_last is high only on the parity chunk; the grant window moves to the parity chunk's handshake.
  - Each word occupies NCHUNK+1 cycles; cnt counts 0..NCHUNK.
  - Parity accumulator clears on grant and on reset.
- Undefined: no parity chunk, no accumulator logic; behaviour as above.

Test Plan:
- Single word: reset, then req0_valid=1, req0_data=32'hDEADBEEF, out_ready=1.
  -> req0_ready pulse for 1 cycle.
  -> out_data DE, AD, BE, EF on 4 consecutive cycles; out_last only on EF; out_src=0; busy drops the following cycle.
- Contention: req0 and req1 both valid from reset (words 32'h11223344 and 32'h55667788).
  -> req0 granted first, then req1 in the last-chunk cycle.
  -> 8 contiguous chunks 11..44 then 55..88; out_src switches 0->1 with no gap.
- Fairness: both requesters continuously valid for 4 words.
  -> grant order 0,1,0,1; each ready pulses exactly twice.
- Backpressure: out_ready=0 for 3 cycles after the first chunk of 32'hA1B2C3D4.
  -> A1 held stable with out_valid=1 for 4 cycles; remaining chunks follow unchanged; no requester ready during the stall.
- Reset mid-word: assert rst after chunk 2 of 32'hCAFEF00D, release with no requests.
  -> out_valid=0 immediately (asynchronous); no further chunks; prio=0.
- Parity (macro defined): word 32'h01020304.
  -> chunks 01,02,03,04,04; out_last only on the fifth chunk.
